// File: rtl/cache_sim_pkg.sv
// Shared types for the cache simulator: fixed-width aliases, trace opcodes,
// sequencer FSM states and the default-width trace record.
package cache_sim_pkg;

    typedef logic [15:0] u16;
    typedef logic [31:0] u32;

    localparam int ADDR_W_DEF = 16;
    localparam int OPC_W_DEF  = 4;

    typedef enum logic [3:0] {
        OP_READ  = 4'd0,
        OP_WRITE = 4'd1,
        OP_FETCH = 4'd2,
        OP_CLEAR = 4'd8,
        OP_PRINT = 4'd9
    } trace_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_CTRL,
        S_FINAL,
        S_DONE
    } seq_state_e;

    typedef struct packed {
        logic [OPC_W_DEF-1:0] opcode;
        u16                   address;
    } trace_rec_t;

endpackage

// File: rtl/trace_sequencer_if.sv
// Record-in and access-out handshakes of the trace sequencer.
// slave = sequencer side, master = trace source / cache side.
interface trace_sequencer_if #(
    parameter int ADDRESS_SIZE = 16,
    parameter int OPC_W        = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OPC_W-1:0]        in_opcode;
    logic [ADDRESS_SIZE-1:0] in_address;
    logic                    acc_valid;
    logic                    acc_ready;
    logic                    acc_rw;
    logic [ADDRESS_SIZE-1:0] acc_address;

    modport master (
        output in_valid, in_opcode, in_address, acc_ready,
        input  in_ready, acc_valid, acc_rw, acc_address
    );

    modport slave (
        input  in_valid, in_opcode, in_address, acc_ready,
        output in_ready, acc_valid, acc_rw, acc_address
    );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; push is refused while
// full even when a pop happens in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];
endmodule

// File: rtl/trace_sequencer.sv
// Trace sequencer: buffers trace records, issues cache accesses, turns control
// opcodes into clear/dump pulses. Optional TRACE_SEQ_OPCODE_CHECK_EN adds illegal-opcode reporting.
//
// state | meaning
// IDLE  | FIFO empty; may head straight into processing or, once drained after trace_done, FINAL
// RUN   | pop access records into the output slot, drop illegal ones
// FLUSH | control record at head; wait for the output slot to drain
// CTRL  | pop control record, pulse cache_clear or stats_dump
// FINAL | issue the closing stats_dump
// DONE  | trace finished; records still accepted but ignored
module trace_sequencer
    import cache_sim_pkg::*;
#(
    parameter int ADDRESS_SIZE = 16,
    parameter int DEPTH        = 8,
    parameter int OPC_W        = 4
) (
    input  logic clk,
    input  logic reset,
    trace_sequencer_if.slave bus,
    input  logic trace_done,
    output logic cache_clear,
    output logic stats_dump,
    output logic done,
    output u32   cnt_reads,
    output u32   cnt_writes,
    output u32   cnt_fetches,
    output u32   cnt_ctrl
`ifdef TRACE_SEQ_OPCODE_CHECK_EN
   ,output logic err_illegal,
    output u32   cnt_illegal
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OPC_W-1:0]        opcode;
        logic [ADDRESS_SIZE-1:0] address;
    } rec_t;

    seq_state_e state, state_nxt;
    rec_t       head, wr_rec;
    logic       fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic       push, pop, load, clear_nxt, dump_nxt;
    logic       done_latch, acc_valid_q, acc_rw_q, slot_free;
    logic [ADDRESS_SIZE-1:0] acc_address_q;
    logic       is_rd, is_wr, is_fe, is_clr, is_prt, is_acc, is_ctl;

    assign wr_rec       = '{opcode: bus.in_opcode, address: bus.in_address};
    assign bus.in_ready = !reset && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;

    trace_fifo #(.DEPTH(DEPTH), .WIDTH($bits(rec_t))) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign is_rd  = head.opcode == OPC_W'(OP_READ);
    assign is_wr  = head.opcode == OPC_W'(OP_WRITE);
    assign is_fe  = head.opcode == OPC_W'(OP_FETCH);
    assign is_clr = head.opcode == OPC_W'(OP_CLEAR);
    assign is_prt = head.opcode == OPC_W'(OP_PRINT);
    assign is_acc = is_rd || is_wr || is_fe;
    assign is_ctl = is_clr || is_prt;

    assign slot_free = !acc_valid_q || bus.acc_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        clear_nxt = 1'b0;
        dump_nxt  = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (!fifo_empty) begin
                    state_nxt = S_RUN;
                    if (is_ctl) begin
                        state_nxt = S_FLUSH;
                    end else if (is_acc) begin
                        pop  = slot_free;
                        load = slot_free;
                    end else begin
                        pop = 1'b1;
                    end
                end else if (state == S_RUN) begin
                    state_nxt = S_IDLE;
                end else if (done_latch && !acc_valid_q && fifo_count == '0) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FLUSH: if (!acc_valid_q) state_nxt = S_CTRL;
            S_CTRL: begin
                pop       = 1'b1;
                clear_nxt = is_clr;
                dump_nxt  = is_prt;
                state_nxt = S_RUN;
            end
            S_FINAL: begin
                dump_nxt  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            done_latch    <= 1'b0;
            acc_valid_q   <= 1'b0;
            acc_rw_q      <= 1'b0;
            acc_address_q <= '0;
            cache_clear   <= 1'b0;
            stats_dump    <= 1'b0;
            cnt_reads     <= '0;
            cnt_writes    <= '0;
            cnt_fetches   <= '0;
            cnt_ctrl      <= '0;
        end else begin
            state       <= state_nxt;
            cache_clear <= clear_nxt;
            stats_dump  <= dump_nxt;
            if (trace_done) done_latch <= 1'b1;
            if (load) begin
                acc_valid_q   <= 1'b1;
                acc_rw_q      <= is_wr;
                acc_address_q <= head.address;
            end else if (bus.acc_ready) begin
                acc_valid_q <= 1'b0;
            end
            if (pop && is_rd)        cnt_reads   <= cnt_reads + 32'd1;
            if (pop && is_wr)        cnt_writes  <= cnt_writes + 32'd1;
            if (pop && is_fe)        cnt_fetches <= cnt_fetches + 32'd1;
            if (state == S_CTRL)     cnt_ctrl    <= cnt_ctrl + 32'd1;
        end
    end

`ifdef TRACE_SEQ_OPCODE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal <= 1'b0;
            cnt_illegal <= '0;
        end else if (pop && !is_acc && !is_ctl) begin
            err_illegal <= 1'b1;
            cnt_illegal <= cnt_illegal + 32'd1;
        end
    end
`endif

    assign bus.acc_valid   = acc_valid_q;
    assign bus.acc_rw      = acc_rw_q;
    assign bus.acc_address = acc_address_q;
    assign done            = (state == S_DONE);
endmodule

// File: tb/tb_trace_sequencer.sv
// Directed self-checking bench for trace_sequencer; honours TRACE_SEQ_OPCODE_CHECK_EN.
module tb_trace_sequencer;
    import cache_sim_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trace_done = 1'b0;
    logic cache_clear, stats_dump, done;
    u32   cnt_reads, cnt_writes, cnt_fetches, cnt_ctrl;
`ifdef TRACE_SEQ_OPCODE_CHECK_EN
    logic err_illegal;
    u32   cnt_illegal;
`endif

    int checks = 0;
    int failures = 0;

    trace_sequencer_if #(.ADDRESS_SIZE(16), .OPC_W(4)) bus ();

    trace_sequencer #(.ADDRESS_SIZE(16), .DEPTH(8), .OPC_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .trace_done  (trace_done),
        .cache_clear (cache_clear),
        .stats_dump  (stats_dump),
        .done        (done),
        .cnt_reads   (cnt_reads),
        .cnt_writes  (cnt_writes),
        .cnt_fetches (cnt_fetches),
        .cnt_ctrl    (cnt_ctrl)
`ifdef TRACE_SEQ_OPCODE_CHECK_EN
       ,.err_illegal (err_illegal),
        .cnt_illegal (cnt_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] addr);
        bus.in_valid   = v;
        bus.in_opcode  = op;
        bus.in_address = addr;
    endtask

    initial begin
        int rd_hs, clr_first, wr_first, clr_n, act, fetch_seen, dump_n, all_done;
        logic fetch_rw;
        logic [15:0] fetch_addr;

        drive(1'b0, 4'd0, 16'h0);
        bus.acc_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_acc_valid", {31'd0, bus.acc_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt_reads", cnt_reads, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // single read, latency 2
        bus.acc_ready = 1'b1;
        drive(1'b1, 4'd0, 16'h1234);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0);
        chk("t1_valid_n1", {31'd0, bus.acc_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_n2", {31'd0, bus.acc_valid}, 32'd1);
        chk("t1_rw", {31'd0, bus.acc_rw}, 32'd0);
        chk("t1_addr", {16'd0, bus.acc_address}, 32'h1234);
        chk("t1_cnt_reads", cnt_reads, 32'd1);
        @(negedge clk);
        chk("t1_slot_empty", {31'd0, bus.acc_valid}, 32'd0);

        // fill FIFO plus slot under backpressure
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("t2_in_ready_fill", {31'd0, bus.in_ready}, 32'd1);
            drive(1'b1, 4'd1, 16'h0100 + 16'(i));
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 16'h0);
        chk("t2_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_held_valid", {31'd0, bus.acc_valid}, 32'd1);
        chk("t2_held_addr", {16'd0, bus.acc_address}, 32'h0100);
        repeat (3) @(negedge clk);
        chk("t2_held_stable", {16'd0, bus.acc_address}, 32'h0100);
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("t2_drain_valid", {31'd0, bus.acc_valid}, 32'd1);
            chk("t2_drain_addr", {16'd0, bus.acc_address}, 32'h0100 + i);
            chk("t2_drain_rw", {31'd0, bus.acc_rw}, 32'd1);
            @(negedge clk);
        end
        chk("t2_after_valid", {31'd0, bus.acc_valid}, 32'd0);
        chk("t2_cnt_writes", cnt_writes, 32'd9);

        // read, clear, write ordering
        bus.acc_ready = 1'b0;
        drive(1'b1, 4'd0, 16'h0010);
        @(negedge clk);
        drive(1'b1, 4'd8, 16'h0000);
        @(negedge clk);
        drive(1'b1, 4'd1, 16'h0020);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0);
        clr_n = 0;
        for (int i = 0; i < 3; i++) begin
            clr_n += int'(cache_clear);
            @(negedge clk);
        end
        chk("t3_no_clear_while_held", clr_n, 32'd0);
        bus.acc_ready = 1'b1;
        rd_hs = -1; clr_first = -1; wr_first = -1; clr_n = 0; act = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.acc_valid && bus.acc_address == 16'h0010 && rd_hs < 0) rd_hs = t;
            if (cache_clear) begin
                clr_n++;
                if (clr_first < 0) clr_first = t;
            end
            if (bus.acc_valid && bus.acc_address == 16'h0020 && wr_first < 0) wr_first = t;
            act += int'(stats_dump);
            @(negedge clk);
        end
        chk("t3_read_seen", {31'd0, rd_hs >= 0}, 32'd1);
        chk("t3_clear_width", clr_n, 32'd1);
        chk("t3_clear_after_read", {31'd0, clr_first > rd_hs}, 32'd1);
        chk("t3_write_after_clear", {31'd0, wr_first > clr_first}, 32'd1);
        chk("t3_no_dump", act, 32'd0);
        chk("t3_cnt_ctrl", cnt_ctrl, 32'd1);
        chk("t3_cnt_reads", cnt_reads, 32'd2);
        chk("t3_cnt_writes", cnt_writes, 32'd10);

        // illegal opcode dropped
        drive(1'b1, 4'd5, 16'h5555);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0);
        act = 0;
        for (int t = 0; t < 8; t++) begin
            act += int'(bus.acc_valid) + int'(cache_clear) + int'(stats_dump);
            @(negedge clk);
        end
        chk("t5_no_activity", act, 32'd0);
        chk("t5_cnt_reads", cnt_reads, 32'd2);
        chk("t5_cnt_writes", cnt_writes, 32'd10);
        chk("t5_cnt_fetches", cnt_fetches, 32'd0);
        chk("t5_cnt_ctrl", cnt_ctrl, 32'd1);
`ifdef TRACE_SEQ_OPCODE_CHECK_EN
        chk("t5_err_illegal", {31'd0, err_illegal}, 32'd1);
        chk("t5_cnt_illegal", cnt_illegal, 32'd1);
`endif

        // fetch then end of trace
        chk("t4_done_before", {31'd0, done}, 32'd0);
        drive(1'b1, 4'd2, 16'hFFF0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0);
        fetch_seen = 0; dump_n = 0; fetch_rw = 1'b1; fetch_addr = 16'h0;
        for (int t = 0; t < 15; t++) begin
            trace_done = (t == 0);
            if (bus.acc_valid) begin
                fetch_seen++;
                fetch_rw   = bus.acc_rw;
                fetch_addr = bus.acc_address;
            end
            dump_n += int'(stats_dump);
            @(negedge clk);
        end
        trace_done = 1'b0;
        chk("t4_fetch_seen", fetch_seen, 32'd1);
        chk("t4_fetch_rw", {31'd0, fetch_rw}, 32'd0);
        chk("t4_fetch_addr", {16'd0, fetch_addr}, 32'hFFF0);
        chk("t4_cnt_fetches", cnt_fetches, 32'd1);
        chk("t4_done", {31'd0, done}, 32'd1);
        all_done = 1; act = 0;
        for (int t = 0; t < 20; t++) begin
            drive(t == 0, 4'd0, 16'h0777);
            if (!done) all_done = 0;
            act += int'(bus.acc_valid) + int'(cache_clear);
            dump_n += int'(stats_dump);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 16'h0);
        chk("t4_dump_once", dump_n, 32'd1);
        chk("t4_done_sticky", all_done, 32'd1);
        chk("t4_done_ignores_input", act, 32'd0);

        // reset mid-stream
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.acc_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd0, 16'h0A00 + 16'(i));
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 16'h0);
        chk("t6_slot_loaded", {31'd0, bus.acc_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, bus.acc_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("t6_rst_cnt_reads", cnt_reads, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_pulses", {30'd0, cache_clear, stats_dump}, 32'd0);
        reset = 1'b0;
        bus.acc_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        act = 0;
        for (int t = 0; t < 6; t++) begin
            act += int'(bus.acc_valid);
            @(negedge clk);
        end
        chk("t6_no_residual", act, 32'd0);
        drive(1'b1, 4'd0, 16'h0BEE);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0);
        @(negedge clk);
        chk("t6_new_valid", {31'd0, bus.acc_valid}, 32'd1);
        chk("t6_new_addr", {16'd0, bus.acc_address}, 32'h0BEE);
        chk("t6_new_cnt_reads", cnt_reads, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
